psum_accum: RTL

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_accum_pkg.sv | 16 +
 rtl/psum_lane_sat.sv | 53 +++++
 rtl/psum_accum.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/psum_accum_pkg.sv
// Shared types and default widths for the partial-sum accumulator and its lanes.
// Holds the controller state encoding and the OP SRAM address width.
package psum_accum_pkg;
  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int ACC_BW_DEF  = 20;
  localparam int OP_AW       = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LAST,
    ST_WRITE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/psum_lane_sat.sv
// One lane: sign-extending accumulator plus signed saturation to PSUM_BW, and
// zeroing of negative results when PSUM_ACCUM_RELU_EN is defined. Result is combinational on the accumulator.
module psum_lane_sat
  import psum_accum_pkg::*;
#(
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int ACC_BW  = ACC_BW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               add_en,
  input  logic [PSUM_BW-1:0] din,
  output logic [PSUM_BW-1:0] dout
);

  logic [ACC_BW-1:0]         acc_q, acc_d;
  logic [ACC_BW-PSUM_BW:0]   top_bits;
  logic [PSUM_BW-1:0]        sat;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + {{(ACC_BW-PSUM_BW){din[PSUM_BW-1]}}, din};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // In range only when every bit above the PSUM sign bit matches it.
  assign top_bits = acc_q[ACC_BW-1:PSUM_BW-1];

  always_comb begin
    sat = acc_q[PSUM_BW-1:0];
    if (top_bits != '0 && top_bits != '1) begin
      sat = acc_q[ACC_BW-1] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
    end
`ifdef PSUM_ACCUM_RELU_EN
    dout = sat[PSUM_BW-1] ? '0 : sat;
`else
    dout = sat;
`endif
  end

endmodule

// File: rtl/psum_accum.sv
// Sums P partial-sum words per output vector from OP SRAM and writes the saturated result back (PSUM_ACCUM_RELU_EN zeroes negatives).
// Latency: P+2 cycles per output, done pulses num_out*(P+2)+1 cycles after start; no backpressure, SRAM accepts every cycle.
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int ACC_BW  = ACC_BW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [5:0]             num_out,
  input  logic [3:0]             num_pass,
  input  logic [OP_AW-1:0]       src_base,
  input  logic [OP_AW-1:0]       pass_stride,
  input  logic [OP_AW-1:0]       dst_base,
  output logic                   busy,
  output logic                   done,
  input  logic [COL*PSUM_BW-1:0] OP_q,
  output logic [COL*PSUM_BW-1:0] OP_d,
  output logic [OP_AW-1:0]       OP_addr,
  output logic                   OP_cen,
  output logic                   OP_wen
);

  state_t           state_q, state_d;
  logic [5:0]       num_out_q, num_out_d;
  logic [3:0]       num_pass_q, num_pass_d;
  logic [OP_AW-1:0] src_base_q, src_base_d;
  logic [OP_AW-1:0] stride_q, stride_d;
  logic [OP_AW-1:0] dst_base_q, dst_base_d;
  logic [3:0]       pass_q, pass_d;
  logic [5:0]       out_q, out_d;
  logic             rd_vld_q, rd_vld_d;

  logic [OP_AW-1:0]       rd_addr, wr_addr;
  logic [COL*PSUM_BW-1:0] lane_sat;
  logic                   acc_clr;

  // 9-bit arithmetic gives the modulo-512 wrap for free.
  assign rd_addr = src_base_q + (OP_AW'(pass_q) * stride_q) + OP_AW'(out_q);
  assign wr_addr = dst_base_q + OP_AW'(out_q);

  always_comb begin
    state_d    = state_q;
    num_out_d  = num_out_q;
    num_pass_d = num_pass_q;
    src_base_d = src_base_q;
    stride_d   = stride_q;
    dst_base_d = dst_base_q;
    pass_d     = pass_q;
    out_d      = out_q;
    rd_vld_d   = (state_q == ST_READ);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_out_d  = num_out;
          num_pass_d = (num_pass == 4'd0) ? 4'd1 : num_pass;
          src_base_d = src_base;
          stride_d   = pass_stride;
          dst_base_d = dst_base;
          pass_d     = '0;
          out_d      = '0;
          state_d    = (num_out == 6'd0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (pass_q == num_pass_q - 4'd1) begin
          pass_d  = '0;
          state_d = ST_LAST;
        end else begin
          pass_d = pass_q + 4'd1;
        end
      end
      ST_LAST:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (out_q == num_out_q - 6'd1) begin
          state_d = ST_DONE;
        end else begin
          out_d   = out_q + 6'd1;
          state_d = ST_READ;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      num_out_q  <= '0;
      num_pass_q <= '0;
      src_base_q <= '0;
      stride_q   <= '0;
      dst_base_q <= '0;
      pass_q     <= '0;
      out_q      <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_out_q  <= num_out_d;
      num_pass_q <= num_pass_d;
      src_base_q <= src_base_d;
      stride_q   <= stride_d;
      dst_base_q <= dst_base_d;
      pass_q     <= pass_d;
      out_q      <= out_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // Clearing in IDLE/WRITE means every READ entry starts from zero.
  assign acc_clr = (state_q == ST_IDLE) || (state_q == ST_WRITE);

  for (genvar g = 0; g < COL; g++) begin : g_lane
    psum_lane_sat #(
      .PSUM_BW(PSUM_BW),
      .ACC_BW (ACC_BW)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (acc_clr),
      .add_en(rd_vld_q),
      .din   (OP_q[g*PSUM_BW +: PSUM_BW]),
      .dout  (lane_sat[g*PSUM_BW +: PSUM_BW])
    );
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    OP_cen  = 1'b1;
    OP_wen  = 1'b1;
    OP_addr = '0;
    OP_d    = '0;
    if (state_q == ST_READ) begin
      OP_cen  = 1'b0;
      OP_addr = rd_addr;
    end else if (state_q == ST_WRITE) begin
      OP_cen  = 1'b0;
      OP_wen  = 1'b0;
      OP_addr = wr_addr;
      OP_d    = lane_sat;
    end
  end

endmodule
